// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller:
//            sequencer state encoding, register-index type, zero register,
//            and the load-use compare helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [0:REG_W-1] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_ARM  = 2'd1,
    MC_WAIT = 2'd2
  } state_t;

  // A load into r0 never creates a dependency; rt only matters when the
  // ID instruction actually reads it as a source.
  function automatic logic load_use(
    input logic     ex_mem_read,
    input reg_idx_t ex_dest,
    input reg_idx_t id_rs,
    input reg_idx_t id_rt,
    input logic     id_uses_rt
  );
    return ex_mem_read && (ex_dest != REG_ZERO) &&
           ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Bundles the hazard controller's pipeline-status inputs and its
//            stage-control / status outputs.
// Ports    : slave  - controller side (status in, controls/counters out)
//            master - pipeline side (drives status, observes controls)
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  // Status from ID / EX / multi-cycle unit
  reg_idx_t   id_rs;
  reg_idx_t   id_rt;
  logic       id_uses_rt;
  logic       id_jump;
  logic       id_mc_op;
  logic       ex_MemRead;
  reg_idx_t   ex_DestReg;
  logic       ex_branch_tkn;
  logic       mc_done;

  // Stage controls and status
  logic       pc_we;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_we;
  logic       idex_kill;
  logic       exmem_kill;
  logic       mc_busy;
  logic       mc_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump, id_mc_op,
           ex_MemRead, ex_DestReg, ex_branch_tkn, mc_done,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_kill, exmem_kill,
           mc_busy, mc_err, stall_cnt, flush_cnt
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump, id_mc_op,
           ex_MemRead, ex_DestReg, ex_branch_tkn, mc_done,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_kill, exmem_kill,
           mc_busy, mc_err, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hz_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : hz_sat_counter
// Purpose  : Saturating up-counter for pipeline performance statistics.
// Ports    : clk, rst (sync, active-high), i_inc (count enable),
//            o_cnt (current count, sticks at all-ones)
// Revision : 1.0 - initial release
// ============================================================================
module hz_sat_counter #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_inc,
  output logic [CNT_W-1:0]      o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline sequencer for the 5-stage integer core. Generates
//            PC / IF/ID / ID/EX write-enables and IF/ID, ID/EX, EX/MEM
//            kill controls for taken branches, jumps, load-use hazards and
//            multi-cycle execute ops (with watchdog abort).
// Ports    : clk, rst (sync, active-high)
//            bus : pipe_hazard_ctrl_if.slave (status in, controls out,
//                  mc_busy/mc_err status, stall/flush performance counters)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MC_MAX_CYC = 32,
  parameter int CNT_W      = 32
) (
  input  wire logic           clk,
  input  wire logic           rst,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam int WD_W = $clog2(MC_MAX_CYC + 1);

  state_t           r_state;
  state_t           w_next;
  logic [WD_W-1:0]  r_wd;
  logic             r_mc_err;

  logic w_pc_we, w_ifid_we, w_ifid_flush, w_idex_we;
  logic w_idex_kill, w_exmem_kill, w_mc_busy, w_wd_expire;
  logic w_load_use;

  assign w_load_use = load_use(bus.ex_MemRead, bus.ex_DestReg,
                               bus.id_rs, bus.id_rt, bus.id_uses_rt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pc_we      = 1'b1;
    w_ifid_we    = 1'b1;
    w_idex_we    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_kill  = 1'b0;
    w_exmem_kill = 1'b0;
    w_mc_busy    = 1'b0;
    w_wd_expire  = 1'b0;

    case (r_state)
      RUN: begin
        // A taken branch squashes the ID instruction, so any hazard it
        // would have raised is moot.
        if (bus.ex_branch_tkn) begin
          w_ifid_flush = 1'b1;
          w_idex_kill  = 1'b1;
        end else if (w_load_use) begin
          w_pc_we     = 1'b0;
          w_ifid_we   = 1'b0;
          w_idex_kill = 1'b1;
        end else if (bus.id_jump) begin
          w_ifid_flush = 1'b1;
        end else if (bus.id_mc_op) begin
          w_next = MC_ARM;
        end
      end

      MC_ARM: begin
        if (bus.mc_done) begin
          w_next = RUN;
        end else begin
          w_pc_we      = 1'b0;
          w_ifid_we    = 1'b0;
          w_idex_we    = 1'b0;
          w_exmem_kill = 1'b1;
          w_next       = MC_WAIT;
        end
      end

      MC_WAIT: begin
        w_pc_we      = 1'b0;
        w_ifid_we    = 1'b0;
        w_idex_we    = 1'b0;
        w_exmem_kill = 1'b1;
        w_mc_busy    = 1'b1;
        if (bus.mc_done) begin
          w_exmem_kill = 1'b0;
          w_next       = RUN;
        end else if (r_wd == WD_W'(MC_MAX_CYC)) begin
          // Give up on the op; it stays killed out of MEM.
          w_wd_expire = 1'b1;
          w_next      = RUN;
        end
      end

      default: begin
        w_next = RUN;
      end
    endcase

    if (rst) begin
      w_pc_we      = 1'b0;
      w_ifid_we    = 1'b0;
      w_idex_we    = 1'b0;
      w_ifid_flush = 1'b0;
      w_idex_kill  = 1'b1;
      w_exmem_kill = 1'b1;
      w_mc_busy    = 1'b0;
      w_wd_expire  = 1'b0;
      w_next       = RUN;
    end
  end

  // Watchdog counts cycles the op has spent in EX, starting at 1 in MC_ARM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd <= '0;
    end else begin
      case (r_state)
        MC_ARM:  r_wd <= WD_W'(1);
        MC_WAIT: r_wd <= r_wd + WD_W'(1);
        default: r_wd <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mc_err <= 1'b0;
    end else if (w_wd_expire) begin
      r_mc_err <= 1'b1;
    end
  end

  hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (~w_pc_we),
    .o_cnt (bus.stall_cnt)
  );

  hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_ifid_flush),
    .o_cnt (bus.flush_cnt)
  );

  assign bus.pc_we      = w_pc_we;
  assign bus.ifid_we    = w_ifid_we;
  assign bus.ifid_flush = w_ifid_flush;
  assign bus.idex_we    = w_idex_we;
  assign bus.idex_kill  = w_idex_kill;
  assign bus.exmem_kill = w_exmem_kill;
  assign bus.mc_busy    = w_mc_busy;
  assign bus.mc_err     = r_mc_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl. Each cycle
//            pushes the expected control vector to a scoreboard, then pops
//            and compares it against the DUT; counters are checked every
//            cycle against a small saturating model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MAXC = 8;
  localparam int CW   = 4;

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_kill, exmem_kill, mc_busy}
  localparam logic [6:0] V_RST   = 7'b0000110;
  localparam logic [6:0] V_RUN   = 7'b1101000;
  localparam logic [6:0] V_LU    = 7'b0001100;
  localparam logic [6:0] V_BR    = 7'b1111100;
  localparam logic [6:0] V_JMP   = 7'b1111000;
  localparam logic [6:0] V_ARM   = 7'b0000010;
  localparam logic [6:0] V_WAIT  = 7'b0000011;
  localparam logic [6:0] V_WDONE = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) ifc ();

  pipe_hazard_ctrl #(.MC_MAX_CYC(MAXC), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_q[$];
  string      tag_q[$];
  logic [CW-1:0] exp_stall = '0;
  logic [CW-1:0] exp_flush = '0;

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic jmp, input logic mcop,
                       input logic mrd, input logic [4:0] dst,
                       input logic tkn, input logic done);
    @(posedge clk);
    #1;
    rst               = r;
    ifc.id_rs         = rs;
    ifc.id_rt         = rt;
    ifc.id_uses_rt    = urt;
    ifc.id_jump       = jmp;
    ifc.id_mc_op      = mcop;
    ifc.ex_MemRead    = mrd;
    ifc.ex_DestReg    = dst;
    ifc.ex_branch_tkn = tkn;
    ifc.mc_done       = done;
  endtask

  task automatic idle(input logic r, input logic done);
    drive(r, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, done);
  endtask

  task automatic expect_out(input logic [6:0] v, input logic err, input string tag);
    logic [7:0] obs;
    logic [7:0] e;
    string      t;
    sb_q.push_back({v, err});
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {ifc.pc_we, ifc.ifid_we, ifc.ifid_flush, ifc.idex_we,
           ifc.idex_kill, ifc.exmem_kill, ifc.mc_busy, ifc.mc_err};
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", t, obs, e);
    end
    checks++;
    assert (ifc.stall_cnt === exp_stall) else begin
      failures++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", t, ifc.stall_cnt, exp_stall);
    end
    checks++;
    assert (ifc.flush_cnt === exp_flush) else begin
      failures++;
      $error("FAIL %s flush_cnt observed=%0d expected=%0d", t, ifc.flush_cnt, exp_flush);
    end
    // Counter model: value seen next cycle reflects this cycle's controls.
    if (rst) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (!e[7] && exp_stall != {CW{1'b1}}) exp_stall = exp_stall + 1'b1;
      if (e[5]  && exp_flush != {CW{1'b1}}) exp_flush = exp_flush + 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ifc.id_rs = '0; ifc.id_rt = '0; ifc.id_uses_rt = 1'b0; ifc.id_jump = 1'b0;
    ifc.id_mc_op = 1'b0; ifc.ex_MemRead = 1'b0; ifc.ex_DestReg = '0;
    ifc.ex_branch_tkn = 1'b0; ifc.mc_done = 1'b0;

    // Reset state
    idle(1'b1, 1'b0); expect_out(V_RST, 1'b0, "reset0");
    idle(1'b1, 1'b0); expect_out(V_RST, 1'b0, "reset1");
    idle(1'b0, 1'b0); expect_out(V_RUN, 1'b0, "run_idle");

    // Load-use on rs: one bubble, then load is in MEM
    drive(1'b0, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    expect_out(V_LU, 1'b0, "lu_rs");
    idle(1'b0, 1'b0); expect_out(V_RUN, 1'b0, "lu_release");

    // No-stall corner cases: r0 destination, rt not used
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    expect_out(V_RUN, 1'b0, "lu_r0");
    drive(1'b0, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    expect_out(V_RUN, 1'b0, "lu_rt_unused");
    drive(1'b0, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    expect_out(V_LU, 1'b0, "lu_rt_used");

    // Branch wins over load-use and jump
    drive(1'b0, 5'd5, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    expect_out(V_BR, 1'b0, "branch_prio");
    drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_out(V_JMP, 1'b0, "jump");

    // Spurious mc_done in RUN
    idle(1'b0, 1'b1); expect_out(V_RUN, 1'b0, "spurious_done");
    idle(1'b0, 1'b0); expect_out(V_RUN, 1'b0, "spurious_after");

    // Multi-cycle op, done on 4th MC_WAIT cycle; branch/jump ignored meanwhile
    drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_out(V_RUN, 1'b0, "mc_issue");
    idle(1'b0, 1'b0); expect_out(V_ARM, 1'b0, "mc_arm");
    drive(1'b0, 5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    expect_out(V_WAIT, 1'b0, "mc_wait1_ignore");
    idle(1'b0, 1'b0); expect_out(V_WAIT, 1'b0, "mc_wait2");
    idle(1'b0, 1'b0); expect_out(V_WAIT, 1'b0, "mc_wait3");
    idle(1'b0, 1'b1); expect_out(V_WDONE, 1'b0, "mc_wait4_done");
    idle(1'b0, 1'b0); expect_out(V_RUN, 1'b0, "mc_back_run");

    // Single-cycle completion in MC_ARM
    drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_out(V_RUN, 1'b0, "mc1_issue");
    idle(1'b0, 1'b1); expect_out(V_RUN, 1'b0, "mc1_arm_done");
    idle(1'b0, 1'b0); expect_out(V_RUN, 1'b0, "mc1_after");

    // Watchdog abort after MAXC cycles in MC_WAIT; counters saturate here
    drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_out(V_RUN, 1'b0, "wd_issue");
    idle(1'b0, 1'b0); expect_out(V_ARM, 1'b0, "wd_arm");
    for (int i = 1; i <= MAXC; i++) begin
      idle(1'b0, 1'b0);
      expect_out(V_WAIT, 1'b0, $sformatf("wd_wait%0d", i));
    end
    idle(1'b0, 1'b0); expect_out(V_RUN, 1'b1, "wd_err_set");
    idle(1'b0, 1'b0); expect_out(V_RUN, 1'b1, "wd_err_sticky");
    checks++;
    assert (ifc.stall_cnt === 4'hF) else begin
      failures++;
      $error("FAIL stall_saturate observed=%0d expected=15", ifc.stall_cnt);
    end

    // Reset in the middle of MC_WAIT; late mc_done ignored
    drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_out(V_RUN, 1'b1, "rst_mc_issue");
    idle(1'b0, 1'b0); expect_out(V_ARM, 1'b1, "rst_mc_arm");
    idle(1'b0, 1'b0); expect_out(V_WAIT, 1'b1, "rst_mc_wait");
    idle(1'b1, 1'b0); expect_out(V_RST, 1'b1, "rst_mid_wait");
    idle(1'b0, 1'b1); expect_out(V_RUN, 1'b0, "rst_late_done");
    idle(1'b0, 1'b0); expect_out(V_RUN, 1'b0, "rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
